parallel_in_serial_out_tx: RTL and testbench

PARALLEL_IN_SERIAL_OUT_TX -- requirements
Module: parallel_in_serial_out_tx

---
 rtl/parallel_in_serial_out_tx.sv | 207 ++++++++++++++++++++
 tb/tb_parallel_in_serial_out_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_in_serial_out_tx.sv
// ----------------------------------------------------------------------------
// parallel_in_serial_out_tx
//
// Purpose:
//   Accepts a WIDTH-bit word through a valid/ready handshake and shifts it
//   out one bit per clock on serial_out. Frames can be chained back-to-back:
//   a word offered during the final bit cycle of a frame starts the next frame
//   in the following cycle, with no idle gap.
//
// Optional feature (compile-time macro):
//   PISO_PARITY_EN - when defined, each frame is followed by one extra bit
//                    carrying the even parity (XOR) of the captured word.
//                    load_ready then opens in that parity cycle instead of
//                    the last data cycle. When undefined, no parity logic is
//                    built and frames are exactly WIDTH cycles long.
//
// Parameters:
//   WIDTH      data bits per frame (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset (0 clears everything)
//   parallel_in   word to serialize, sampled only when a load is accepted
//   load_valid    upstream offers parallel_in this cycle
//   load_ready    block can accept a word this cycle (registered)
//   serial_out    current serial bit (0 when idle)
//   serial_valid  serial_out carries a frame bit this cycle
//   frame_start   high only during the first bit of a frame
//   busy          a frame is in progress
// ----------------------------------------------------------------------------
module parallel_in_serial_out_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifndef PISO_PARITY_EN
    // load_ready is registered, so it has to be raised one bit early to be
    // high during the final data bit.
    localparam logic [CNT_W-1:0] PRE_LAST_BIT = CNT_W'(WIDTH - 2);
`endif

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
`endif

    state_t             state_reg;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_next;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic               serial_out_reg;
    logic               serial_valid_reg;
    logic               frame_start_reg;
    logic               busy_reg;
    logic               load_ready_reg;
    logic               load_accept;
`ifdef PISO_PARITY_EN
    logic               parity_reg;
`endif

    // The bit that leaves the register first for the configured bit order.
    function automatic logic head_bit(input logic [WIDTH-1:0] d);
        return (MSB_FIRST != 0) ? d[WIDTH-1] : d[0];
    endfunction

    // One-position shift toward the output end, zero fill at the far end.
    // After a full frame the register has drained to zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shift_next[gi] = 1'b0;
                end else begin : g_move
                    assign shift_next[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shift_next[gi] = 1'b0;
                end else begin : g_move
                    assign shift_next[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    // load_ready_reg is only ever high in IDLE or in the last cycle of a
    // frame, so this single term covers both fresh and chained loads.
    assign load_accept = load_valid && load_ready_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            serial_out_reg   <= 1'b0;
            serial_valid_reg <= 1'b0;
            frame_start_reg  <= 1'b0;
            busy_reg         <= 1'b0;
            load_ready_reg   <= 1'b1;
`ifdef PISO_PARITY_EN
            parity_reg       <= 1'b0;
`endif
        end else if (load_accept) begin
            // New frame: first bit is presented in the very next cycle, so
            // the output register is loaded straight from parallel_in.
            state_reg        <= ST_SHIFT;
            shift_reg        <= parallel_in;
            bit_cnt_reg      <= '0;
            serial_out_reg   <= head_bit(parallel_in);
            serial_valid_reg <= 1'b1;
            frame_start_reg  <= 1'b1;
            busy_reg         <= 1'b1;
            load_ready_reg   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg       <= ^parallel_in;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Outputs already parked at their idle values.
                end

                ST_SHIFT: begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_reg <= '0;
`ifdef PISO_PARITY_EN
                        state_reg       <= ST_PARITY;
                        shift_reg       <= '0;
                        serial_out_reg  <= parity_reg;
                        frame_start_reg <= 1'b0;
                        load_ready_reg  <= 1'b1;
`else
                        // Last bit done and nothing chained: drop to idle.
                        state_reg        <= ST_IDLE;
                        shift_reg        <= '0;
                        serial_out_reg   <= 1'b0;
                        serial_valid_reg <= 1'b0;
                        frame_start_reg  <= 1'b0;
                        busy_reg         <= 1'b0;
                        load_ready_reg   <= 1'b1;
`endif
                    end else begin
                        bit_cnt_reg     <= bit_cnt_reg + CNT_W'(1);
                        shift_reg       <= shift_next;
                        serial_out_reg  <= head_bit(shift_next);
                        frame_start_reg <= 1'b0;
`ifndef PISO_PARITY_EN
                        load_ready_reg  <= (bit_cnt_reg == PRE_LAST_BIT);
`endif
                    end
                end

`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    // Parity bit done and nothing chained: drop to idle.
                    state_reg        <= ST_IDLE;
                    serial_out_reg   <= 1'b0;
                    serial_valid_reg <= 1'b0;
                    frame_start_reg  <= 1'b0;
                    busy_reg         <= 1'b0;
                    load_ready_reg   <= 1'b1;
                end
`endif

                default: begin
                    state_reg        <= ST_IDLE;
                    shift_reg        <= '0;
                    bit_cnt_reg      <= '0;
                    serial_out_reg   <= 1'b0;
                    serial_valid_reg <= 1'b0;
                    frame_start_reg  <= 1'b0;
                    busy_reg         <= 1'b0;
                    load_ready_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready   = load_ready_reg;
    assign serial_out   = serial_out_reg;
    assign serial_valid = serial_valid_reg;
    assign frame_start  = frame_start_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_parallel_in_serial_out_tx.sv
// ----------------------------------------------------------------------------
// tb_parallel_in_serial_out_tx
//
// Two instances share one stimulus stream: dut_msb (MSB_FIRST=1) and
// dut_lsb (MSB_FIRST=0), both WIDTH=8. A directed table of words with
// hand-written expected bit streams covers the listed scenarios; a random
// phase then compares both instances against a frame-level reference model.
// Output vectors are shown as {serial_out,serial_valid,frame_start,busy,
// load_ready}.
// ----------------------------------------------------------------------------
module tb_parallel_in_serial_out_tx;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;   // cycles per frame

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] parallel_in = '0;

    logic m_ready, m_out, m_valid, m_start, m_busy;
    logic l_ready, l_out, l_valid, l_start, l_busy;

    parallel_in_serial_out_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (m_ready),
        .serial_out   (m_out),
        .serial_valid (m_valid),
        .frame_start  (m_start),
        .busy         (m_busy)
    );

    parallel_in_serial_out_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (l_ready),
        .serial_out   (l_out),
        .serial_valid (l_valid),
        .frame_start  (l_start),
        .busy         (l_busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // ------------------------------------------------------------------
    // Reference model: each lane holds the list of bits its current frame
    // still has to emit, in emission order.
    // ------------------------------------------------------------------
    logic [FL-1:0] mdl_bits [2];
    int            mdl_left [2];
    bit            mdl_first[2];

    function automatic logic [FL-1:0] frame_bits(input logic [W-1:0] w, input bit msb);
        logic [FL-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++)
            v[i] = msb ? w[W-1-i] : w[i];
        if (PAR != 0)
            v[FL-1] = ^w;
        return v;
    endfunction

    function automatic logic [4:0] mdl_out(input int lane);
        if (mdl_left[lane] > 0)
            return {mdl_bits[lane][FL - mdl_left[lane]], 1'b1, mdl_first[lane],
                    1'b1, (mdl_left[lane] == 1)};
        return 5'b00001;
    endfunction

    task automatic mdl_clear();
        for (int l = 0; l < 2; l++) begin
            mdl_left[l]  = 0;
            mdl_first[l] = 1'b0;
            mdl_bits[l]  = '0;
        end
    endtask

    task automatic mdl_update(input logic lv, input logic [W-1:0] din);
        bit rdy;
        for (int l = 0; l < 2; l++) begin
            rdy = (mdl_left[l] <= 1);
            if (mdl_left[l] > 0) mdl_left[l]--;
            mdl_first[l] = 1'b0;
            if (lv && rdy) begin
                mdl_bits[l]  = frame_bits(din, l == 0);
                mdl_left[l]  = FL;
                mdl_first[l] = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [4:0] m_vec();
        return {m_out, m_valid, m_start, m_busy, m_ready};
    endfunction

    function automatic logic [4:0] l_vec();
        return {l_out, l_valid, l_start, l_busy, l_ready};
    endfunction

    // Called at a falling edge: drive inputs, let one rising edge pass,
    // advance the model, return at the next falling edge.
    task automatic tick(input logic rst_v, input logic lv, input logic [W-1:0] din);
        reset       = rst_v;
        load_valid  = lv;
        parallel_in = din;
        if (!rst_v) mdl_clear();
        @(posedge clk);
        if (reset) mdl_update(lv, din);
        else       mdl_clear();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed table. Bit streams are written leftmost-bit-first.
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] msb_bits;
        logic [W-1:0] lsb_bits;
        logic         par;
        bit           chain;     // hold load_valid with the next word
        bit           noise;     // pulse load_valid with 8'h55 mid-frame
        int           abort_k;   // assert reset after checking this bit
    } vec_t;

    vec_t tbl[8];

    logic         eb_m, eb_l, nlv;
    logic [W-1:0] ndin, next_word;
    bit           chained, aborted;
    logic         r_v, lv_v;

    initial begin
        tbl[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0, 1'b0, 1'b0, -1};
        tbl[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1, 1'b0, 1'b0, -1};
        tbl[2] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1, 1'b0, 1'b0, -1};
        tbl[3] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0, 1'b1, 1'b0, -1};
        tbl[4] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0, 1'b0, 1'b0, -1};
        tbl[5] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0, 1'b0, 1'b1, -1};
        tbl[6] = '{8'hF0, 8'b11110000, 8'b00001111, 1'b0, 1'b0, 1'b0, 3};
        tbl[7] = '{8'h81, 8'b10000001, 8'b10000001, 1'b0, 1'b0, 1'b0, -1};

        mdl_clear();
        @(negedge clk);
        @(negedge clk);
        chk("reset_msb", m_vec(), 5'b00001);
        chk("reset_lsb", l_vec(), 5'b00001);
        tick(1'b1, 1'b0, '0);
        chk("idle_msb", m_vec(), 5'b00001);
        chk("idle_lsb", l_vec(), 5'b00001);

        chained = 1'b0;
        for (int i = 0; i < 8; i++) begin
            aborted   = 1'b0;
            next_word = (i < 7) ? tbl[i+1].word : '0;
            if (!chained) tick(1'b1, 1'b1, tbl[i].word);
            for (int k = 0; k < FL; k++) begin
                eb_m = (k < W) ? tbl[i].msb_bits[W-1-k] : tbl[i].par;
                eb_l = (k < W) ? tbl[i].lsb_bits[W-1-k] : tbl[i].par;
                chk($sformatf("v%0d_msb_bit%0d", i, k), m_vec(),
                    {eb_m, 1'b1, (k == 0), 1'b1, (k == FL-1)});
                chk($sformatf("v%0d_lsb_bit%0d", i, k), l_vec(),
                    {eb_l, 1'b1, (k == 0), 1'b1, (k == FL-1)});
                if (k == tbl[i].abort_k) begin
                    reset = 1'b0;
                    mdl_clear();
                    #1;
                    chk($sformatf("v%0d_abort_msb", i), m_vec(), 5'b00001);
                    chk($sformatf("v%0d_abort_lsb", i), l_vec(), 5'b00001);
                    @(negedge clk);
                    tick(1'b0, 1'b0, '0);
                    tick(1'b1, 1'b0, '0);
                    chk($sformatf("v%0d_after_abort_msb", i), m_vec(), 5'b00001);
                    chk($sformatf("v%0d_after_abort_lsb", i), l_vec(), 5'b00001);
                    aborted = 1'b1;
                    break;
                end
                if (k == FL-1) begin
                    nlv  = tbl[i].chain;
                    ndin = tbl[i].chain ? next_word : W'($urandom);
                end else if (tbl[i].noise && k == 3) begin
                    nlv  = 1'b1;
                    ndin = 8'h55;
                end else if (tbl[i].chain) begin
                    nlv  = 1'b1;
                    ndin = next_word;
                end else begin
                    nlv  = 1'b0;
                    ndin = W'($urandom);
                end
                tick(1'b1, nlv, ndin);
            end
            chained = tbl[i].chain;
            if (!chained && !aborted) begin
                chk($sformatf("v%0d_end_msb", i), m_vec(), 5'b00001);
                chk($sformatf("v%0d_end_lsb", i), l_vec(), 5'b00001);
            end
        end

        // Random traffic against the reference model.
        tick(1'b1, 1'b0, '0);
        for (int c = 0; c < 800; c++) begin
            r_v  = ($urandom_range(0, 149) != 0);
            lv_v = ($urandom_range(0, 2) == 0);
            tick(r_v, lv_v, W'($urandom));
            chk($sformatf("rnd%0d_msb", c), m_vec(), mdl_out(0));
            chk($sformatf("rnd%0d_lsb", c), l_vec(), mdl_out(1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
